// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain, its loader and their benches.
// Holds the loader FSM state encoding and the default chain/word sizes.
package scan_pkg;

  // Default sizes for the downstream chain and the config word
  localparam int unsigned SCAN_CHAIN_LEN = 10;
  localparam int unsigned SCAN_WORD_W    = 32;

  // Loader FSM encoding
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_CLEAR     = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_WORD = 3'd2;
  localparam logic [ST_W-1:0] ST_SHIFT     = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE      = 3'd4;

endpackage

// File: rtl/scan_rb_deser.sv
// Readback deserializer: packs serial chain bits LSB-first into WORD_W-bit
// words and pulses rb_valid_o on each full word or on the final chain bit
// (partial word, upper bits zero).
// Ports:
//   clk, rst_n    clock / async active-low reset
//   clear_i       drop any partial word and restart at bit 0
//   bit_valid_i   bit_i is sampled this edge
//   bit_i         serial readback bit
//   last_i        this is the final bit of the load; flush the word
//   rb_word_o     assembled readback word (held until the next word)
//   rb_valid_o    one-cycle pulse, rb_word_o updated
module scan_rb_deser #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              bit_valid_i,
  input  logic              bit_i,
  input  logic              last_i,
  output logic [WORD_W-1:0] rb_word_o,
  output logic              rb_valid_o
);

  localparam int unsigned RC_W = $clog2(WORD_W);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(WORD_W - 1);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [RC_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] merged_c;

  // Accumulate bits; the accumulator restarts at zero after every emit so
  // a flushed partial word is zero-padded.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    valid_d  = 1'b0;
    merged_c = acc_q;
    merged_c[cnt_q] = bit_i;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bit_valid_i) begin
      if (last_i || (cnt_q == RC_LAST)) begin
        word_d  = merged_c;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = merged_c;
        cnt_d = cnt_q + RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign rb_word_o  = word_q;
  assign rb_valid_o = valid_q;

endmodule

// File: rtl/scan_chain_loader.sv
// Scan chain loader: accepts config words over valid/ready, shifts them
// LSB-first into the chain for exactly CHAIN_LEN enabled cycles, returns
// the chain's previous contents as readback words, and sequences the
// chain clear pulse.
// Ports:
//   pmu_tck_in, pmu_rst_n   clock / async active-low reset
//   start, chain_clr_req    load / clear requests (IDLE only, start wins)
//   word_in, word_valid,
//   word_ready              config word handshake
//   sc_data_in, sc_en,
//   sc_clear                drive the chain
//   sc_data_out             serial output of the chain
//   rb_word, rb_valid       readback words
//   busy, done              status
module scan_chain_loader
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN    = SCAN_CHAIN_LEN,
  parameter int unsigned WORD_W       = SCAN_WORD_W,
  parameter int unsigned CLEAR_CYCLES = 3,
  parameter int unsigned CNT_W        = $clog2(CHAIN_LEN + 1)
) (
  input  logic              pmu_tck_in,
  input  logic              pmu_rst_n,
  input  logic              start,
  input  logic              chain_clr_req,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              sc_data_in,
  output logic              sc_en,
  output logic              sc_clear,
  input  logic              sc_data_out,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WB_W  = $clog2(WORD_W);
  localparam int unsigned CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  WB_LAST   = WB_W'(WORD_W - 1);
  localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]   word_bit_q, word_bit_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              word_ready_q, word_ready_d;
  logic              sc_en_q, sc_en_d;
  logic              sc_data_q, sc_data_d;
  logic              sc_clear_q, sc_clear_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              is_last_c, is_bound_c;
  logic [CNT_W-1:0]  bc_nxt_c;
  logic [WB_W-1:0]   wb_nxt_c;
  logic              rb_clear_c, rb_last_c;

  // Next-state and registered-output decode. Outputs are computed for the
  // cycle being entered, so word_ready/sc_en/sc_data_in line up with the
  // state the FSM is in when they are visible.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_bit_d   = word_bit_q;
    shreg_d      = shreg_q;
    clr_cnt_d    = clr_cnt_q;
    word_ready_d = 1'b0;
    sc_en_d      = 1'b0;
    sc_data_d    = 1'b0;
    sc_clear_d   = 1'b0;
    done_d       = 1'b0;
    rb_clear_c   = 1'b0;
    bc_nxt_c     = bit_cnt_q + CNT_W'(1);
    wb_nxt_c     = word_bit_q + WB_W'(1);
    is_last_c    = (bit_cnt_q == BIT_LAST);
    is_bound_c   = (word_bit_q == WB_LAST) && !is_last_c;
    rb_last_c    = (state_q == ST_SHIFT) && is_last_c;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_WAIT_WORD;
          bit_cnt_d    = '0;
          rb_clear_c   = 1'b1;
          word_ready_d = 1'b1;
        end else if (chain_clr_req) begin
          state_d    = ST_CLEAR;
          clr_cnt_d  = '0;
          sc_clear_d = 1'b1;
        end
      end

      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          clr_cnt_d  = clr_cnt_q + CLR_W'(1);
          sc_clear_d = 1'b1;
        end
      end

      ST_WAIT_WORD: begin
        if (word_valid) begin
          state_d    = ST_SHIFT;
          shreg_d    = word_in;
          word_bit_d = '0;
          sc_en_d    = 1'b1;
          sc_data_d  = word_in[0];
        end else begin
          word_ready_d = 1'b1;
        end
      end

      ST_SHIFT: begin
        bit_cnt_d  = bc_nxt_c;
        word_bit_d = wb_nxt_c;
        if (is_last_c) begin
          // Remaining bits of the final word are dropped.
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (is_bound_c) begin
          word_bit_d = '0;
          if (word_valid) begin
            // Back-to-back word, no bubble on sc_en
            shreg_d   = word_in;
            sc_en_d   = 1'b1;
            sc_data_d = word_in[0];
          end else begin
            state_d      = ST_WAIT_WORD;
            word_ready_d = 1'b1;
          end
        end else begin
          sc_en_d      = 1'b1;
          sc_data_d    = shreg_q[wb_nxt_c];
          word_ready_d = (wb_nxt_c == WB_LAST) && (bc_nxt_c != BIT_LAST);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge pmu_tck_in or negedge pmu_rst_n) begin
    if (!pmu_rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      word_bit_q   <= '0;
      shreg_q      <= '0;
      clr_cnt_q    <= '0;
      word_ready_q <= 1'b0;
      sc_en_q      <= 1'b0;
      sc_data_q    <= 1'b0;
      sc_clear_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_bit_q   <= word_bit_d;
      shreg_q      <= shreg_d;
      clr_cnt_q    <= clr_cnt_d;
      word_ready_q <= word_ready_d;
      sc_en_q      <= sc_en_d;
      sc_data_q    <= sc_data_d;
      sc_clear_q   <= sc_clear_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // The chain bit is sampled on every enabled edge, i.e. before that
  // edge's shift replaces it.
  scan_rb_deser #(
    .WORD_W (WORD_W)
  ) u_rb_deser (
    .clk         (pmu_tck_in),
    .rst_n       (pmu_rst_n),
    .clear_i     (rb_clear_c),
    .bit_valid_i (sc_en_q),
    .bit_i       (sc_data_out),
    .last_i      (rb_last_c),
    .rb_word_o   (rb_word),
    .rb_valid_o  (rb_valid)
  );

  assign word_ready = word_ready_q;
  assign sc_en      = sc_en_q;
  assign sc_data_in = sc_data_q;
  assign sc_clear   = sc_clear_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader (CHAIN_LEN=10, WORD_W=8). A behavioural chain
// stub sits on the serial pins; expectations come from word arithmetic.
module tb_scan_chain_loader;

  localparam int unsigned CL  = 10;
  localparam int unsigned WW  = 8;
  localparam int unsigned CC  = 3;
  localparam int          LIM = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          chain_clr_req = 1'b0;
  logic          word_valid = 1'b0;
  logic [WW-1:0] word_in = '0;
  logic          word_ready, sc_data_in, sc_en, sc_clear, sc_data_out;
  logic          rb_valid, busy, done;
  logic [WW-1:0] rb_word;

  logic [CL-1:0] chain = '0;
  logic [CL-1:0] exp_chain = '0;

  int n_vec = 0;
  int n_fail = 0;
  int en_cnt = 0, clr_cyc = 0, done_cnt = 0, stall_cnt = 0, wr_bad = 0;
  logic [15:0]   seq_v = '0;
  logic [WW-1:0] rb_q[$];

  always #5 clk = ~clk;

  scan_chain_loader #(
    .CHAIN_LEN    (CL),
    .WORD_W       (WW),
    .CLEAR_CYCLES (CC)
  ) dut (
    .pmu_tck_in    (clk),
    .pmu_rst_n     (rst_n),
    .start         (start),
    .chain_clr_req (chain_clr_req),
    .word_in       (word_in),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .sc_data_in    (sc_data_in),
    .sc_en         (sc_en),
    .sc_clear      (sc_clear),
    .sc_data_out   (sc_data_out),
    .rb_word       (rb_word),
    .rb_valid      (rb_valid),
    .busy          (busy),
    .done          (done)
  );

  // Chain stub: shifts in at the top, serial output is bit 0.
  always @(posedge clk) begin
    if (sc_clear) chain <= '0;
    else if (sc_en) chain <= {sc_data_in, chain[CL-1:1]};
  end
  assign sc_data_out = chain[0];

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (word_ready && !sc_en && en_cnt > 0) stall_cnt++;
    if (word_ready && (!busy || sc_clear || done)) wr_bad++;
    if (sc_en) begin
      if (en_cnt < 16) seq_v[en_cnt] = sc_data_in;
      en_cnt++;
    end
    if (sc_clear) clr_cyc++;
    if (done) done_cnt++;
    if (rb_valid) rb_q.push_back(rb_word);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_fail++;
    $error("FAIL %s observed=timeout expected=event within %0d cycles", tag, LIM);
  endtask

  task automatic clear_mon();
    en_cnt = 0; clr_cyc = 0; done_cnt = 0; stall_cnt = 0; wr_bad = 0;
    seq_v = '0;
    rb_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_word(input logic [WW-1:0] w);
    int n;
    n = 0;
    word_in = w;
    word_valid = 1'b1;
    while (!word_ready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) timeout("word_ready");
    @(negedge clk);
    word_valid = 1'b0;
    word_in = '0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) timeout(tag);
    repeat (2) @(negedge clk);
  endtask

  // Full two-word load; second word held back 'stall' cycles past the boundary.
  task automatic do_load(input string tag, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                         input int stall, input bit inject);
    logic [CL-1:0] prev;
    logic [15:0]   both;
    prev = exp_chain;
    both = {w1, w0};
    exp_chain = both[CL-1:0];
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(w0);
    for (int i = 0; i < 7 + stall; i++) begin
      if (inject && i == 2) begin
        start = 1'b1;
        chain_clr_req = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      chain_clr_req = 1'b0;
    end
    send_word(w1);
    wait_done({tag, "_done"});
    check({tag, "_en_cycles"}, 32'(en_cnt), 32'(CL));
    check({tag, "_stall"}, 32'(stall_cnt), 32'(stall));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_chain"}, 32'(chain), 32'(exp_chain));
    check({tag, "_seq"}, 32'(seq_v[CL-1:0]), 32'(exp_chain));
    check({tag, "_rb_cnt"}, 32'(rb_q.size()), 32'd2);
    if (rb_q.size() == 2) begin
      check({tag, "_rb0"}, 32'(rb_q[0]), 32'(prev[WW-1:0]));
      check({tag, "_rb1"}, 32'(rb_q[1]), 32'(prev >> WW));
    end
    check({tag, "_clear"}, 32'(clr_cyc), 32'd0);
    check({tag, "_wr_bad"}, 32'(wr_bad), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_clear(input string tag);
    exp_chain = '0;
    clear_mon();
    chain_clr_req = 1'b1;
    @(negedge clk);
    chain_clr_req = 1'b0;
    wait_done({tag, "_done"});
    check({tag, "_clr_cycles"}, 32'(clr_cyc), 32'(CC));
    check({tag, "_en"}, 32'(en_cnt), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_chain"}, 32'(chain), 32'd0);
    check({tag, "_wr_bad"}, 32'(wr_bad), 32'd0);
  endtask

  function automatic logic [31:0] outs();
    return 32'({sc_data_in, sc_en, sc_clear, word_ready, rb_valid, busy, done, rb_word});
  endfunction

  initial begin
    logic [WW-1:0] w0, w1;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", outs(), 32'd0);

    // Basic load, readback of it, stalled repeat
    do_load("basic", 8'hDB, 8'h02, 0, 1'b0);
    check("basic_chain_const", 32'(chain), 32'h2DB);
    do_load("readback", 8'h00, 8'h00, 0, 1'b0);
    do_load("stall", 8'hDB, 8'h02, 5, 1'b0);
    check("stall_chain_const", 32'(chain), 32'h2DB);

    // Clear, then load with ignored requests mid-shift
    do_clear("clear");
    do_load("ignore", 8'hA5, 8'h03, 1, 1'b1);

    // Reset after four shifts
    w0 = 8'h6C;
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(w0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_outputs", outs(), 32'd0);
    exp_chain = {w0[3:0], exp_chain[CL-1:4]};
    repeat (3) @(negedge clk);
    check("midreset_chain", 32'(chain), 32'(exp_chain));
    check("midreset_done", 32'(done_cnt), 32'd0);
    check("midreset_rb", 32'(rb_q.size()), 32'd0);
    check("midreset_held", outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_load("postreset", 8'h3E, 8'h01, 0, 1'b0);

    // Randomized loads and clears
    for (int it = 0; it < 8; it++) begin
      w0 = WW'($urandom);
      w1 = WW'($urandom);
      if ($urandom_range(0, 3) == 0) do_clear("rnd_clear");
      do_load("rnd", w0, w1, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
